// File: rtl/fifo_read_packer.sv
// Packs RATIO consecutive FIFO entries into one wide word with a per-lane keep mask.
// Define PACKER_TIMEOUT_EN to flush a partial word after TIMEOUT idle cycles.
`timescale 1ns/1ps
module fifo_read_packer #(
    parameter int WIDTH   = 8,
    parameter int RATIO   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                     rd_clk,
    input  logic                     reset_n,
    input  logic                     fifo_empty,
    output logic                     fifo_read_en,
    input  logic [WIDTH-1:0]         fifo_read_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH*RATIO-1:0]   out_data,
    output logic [RATIO-1:0]         out_keep
);
    localparam int CNT_W = $clog2(RATIO + 1);
    localparam logic [CNT_W:0] RATIO_W = (CNT_W + 1)'(RATIO);

    typedef enum logic {COLLECT = 1'b0, PRESENT = 1'b1} state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             pending;
    logic             armed;
    logic [CNT_W:0]   inflight;
    logic             last_lane;
    logic             timeout_hit;

    // Lanes already captured plus the read whose data arrives next cycle.
    assign inflight  = {1'b0, count} + (CNT_W + 1)'(pending);
    assign last_lane = (count == CNT_W'(RATIO - 1));

    assign fifo_read_en = reset_n && armed && (state == COLLECT) && !fifo_empty
                          && (inflight < RATIO_W);

`ifdef PACKER_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    logic [IDLE_W-1:0] idle;

    // A read issued this cycle would land after the flush, so it blocks the timeout.
    assign timeout_hit = (state == COLLECT) && (count != '0) && !pending && !fifo_read_en
                         && (idle == IDLE_W'(TIMEOUT - 1));

    always_ff @(posedge rd_clk) begin
        if (!reset_n) begin
            idle <= '0;
        end else if (state != COLLECT || count == '0 || pending) begin
            idle <= '0;
        end else if (idle != IDLE_W'(TIMEOUT)) begin
            idle <= idle + IDLE_W'(1);
        end
    end
`else
    // Without the flush feature a word is only ever presented when full.
    assign timeout_hit = (TIMEOUT < 0);
`endif

    always_ff @(posedge rd_clk) begin
        if (!reset_n) begin
            state     <= COLLECT;
            count     <= '0;
            pending   <= 1'b0;
            armed     <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_valid <= 1'b0;
        end else begin
            armed   <= 1'b1;
            pending <= fifo_read_en;
            case (state)
                COLLECT: begin
                    if (pending) begin
                        for (int i = 0; i < RATIO; i++) begin
                            if (count == CNT_W'(i)) begin
                                out_data[i*WIDTH +: WIDTH] <= fifo_read_data;
                                out_keep[i]                <= 1'b1;
                            end
                        end
                        count <= count + CNT_W'(1);
                        if (last_lane) begin
                            state     <= PRESENT;
                            out_valid <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        state     <= PRESENT;
                        out_valid <= 1'b1;
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        state     <= COLLECT;
                        out_valid <= 1'b0;
                        count     <= '0;
                        out_keep  <= '0;
                        out_data  <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_read_packer.sv
// Bench for fifo_read_packer: queue-based FIFO model plus a lane scoreboard.
// Build with PACKER_TIMEOUT_EN defined to exercise the partial-word flush.
`timescale 1ns/1ps
module tb_fifo_read_packer;
    localparam int WIDTH   = 8;
    localparam int RATIO   = 4;
    localparam int TIMEOUT = 16;
    localparam int OW      = WIDTH * RATIO;
`ifdef PACKER_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic             rd_clk = 1'b0;
    logic             reset_n;
    logic             fifo_empty;
    logic             fifo_read_en;
    logic [WIDTH-1:0] fifo_read_data;
    logic             out_valid;
    logic             out_ready;
    logic [OW-1:0]    out_data;
    logic [RATIO-1:0] out_keep;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] fq[$];
    logic [WIDTH-1:0] got[$];
    logic [OW-1:0]    acc_d[$];
    logic [RATIO-1:0] acc_k[$];
    logic             infl_v = 1'b0;
    logic [WIDTH-1:0] infl_d = '0;
    logic             hold_v = 1'b0;
    logic [OW-1:0]    hold_d = '0;
    bit               hold_empty = 1'b1;
    bit               chk_en = 1'b0;

    always #5 rd_clk = ~rd_clk;

    fifo_read_packer #(.WIDTH(WIDTH), .RATIO(RATIO), .TIMEOUT(TIMEOUT)) dut (
        .rd_clk         (rd_clk),
        .reset_n        (reset_n),
        .fifo_empty     (fifo_empty),
        .fifo_read_en   (fifo_read_en),
        .fifo_read_data (fifo_read_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_keep       (out_keep)
    );

    task automatic refresh();
        fifo_empty = (fq.size() == 0) || hold_empty;
    endtask

    // One clock: scoreboard checks before the edge, FIFO/model update after it.
    task automatic step();
        logic rd, emp, rst_s, acc, vld;
        logic [OW-1:0]    od, exp_d;
        logic [RATIO-1:0] ok, exp_k;
        #1;
        rd = fifo_read_en; emp = fifo_empty; rst_s = reset_n;
        vld = out_valid; acc = out_valid && out_ready;
        od = out_data; ok = out_keep;
        if (chk_en) begin
            total++;
            if (rd && emp) begin
                bad++; $display("FAIL read_while_empty: fifo_read_en=%b fifo_empty=%b", rd, emp);
            end
            total++;
            if (rd && vld) begin
                bad++; $display("FAIL read_while_valid: fifo_read_en=%b out_valid=%b", rd, vld);
            end
            if (!TMO || got.size() == 0 || got.size() == RATIO) begin
                total++;
                if (vld !== (got.size() == RATIO)) begin
                    bad++; $display("FAIL valid_vs_model: out_valid=%b lanes_held=%0d", vld, got.size());
                end
            end
            if (hold_v) begin
                total++;
                if (od !== hold_d) begin
                    bad++; $display("FAIL hold_stable: out_data=%h expected %h", od, hold_d);
                end
            end
            if (acc) begin
                exp_d = '0; exp_k = '0;
                foreach (got[i]) begin
                    exp_d[i*WIDTH +: WIDTH] = got[i];
                    exp_k[i] = 1'b1;
                end
                total++;
                if (od !== exp_d || ok !== exp_k) begin
                    bad++; $display("FAIL word_model: out_data=%h out_keep=%b expected %h %b", od, ok, exp_d, exp_k);
                end
            end
        end
        @(posedge rd_clk);
        #1;
        if (!rst_s) begin
            got.delete();
            hold_v = 1'b0;
        end else begin
            if (acc) begin
                got.delete();
                acc_d.push_back(od);
                acc_k.push_back(ok);
            end
            if (infl_v) got.push_back(infl_d);
            hold_v = vld && !acc;
            hold_d = od;
        end
        infl_v = 1'b0;
        if (rd && !emp && fq.size() > 0) begin
            infl_d = fq.pop_front();
            infl_v = rst_s;
            fifo_read_data = infl_d;
        end
        @(negedge rd_clk);
        refresh();
    endtask

    task automatic do_reset();
        reset_n = 1'b0; hold_empty = 1'b1; out_ready = 1'b0;
        refresh();
        step(); step();
        fq.delete(); acc_d.delete(); acc_k.delete();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; hold_empty = 1'b0; out_ready = 1'b0;
        fq.delete();
        for (int i = 0; i < 4; i++) fq.push_back(WIDTH'($urandom));
        refresh();
        step(); step();
        chk_en = 1'b1;
        #1;
        total++;
        if (fifo_read_en !== 1'b0) begin bad++; $display("FAIL reset_read_en: got %b need 0", fifo_read_en); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b need 0", out_valid); end
        total++;
        if (out_keep !== '0) begin bad++; $display("FAIL reset_keep: got %b need 0", out_keep); end
        total++;
        if (out_data !== '0) begin bad++; $display("FAIL reset_data: got %h need 0", out_data); end
        reset_n = 1'b1;
        #1;
        total++;
        if (fifo_read_en !== 1'b0) begin bad++; $display("FAIL first_cycle_read_en: got %b need 0", fifo_read_en); end
        step();
        #1;
        total++;
        if (fifo_read_en !== 1'b1) begin bad++; $display("FAIL read_after_reset: got %b need 1", fifo_read_en); end
    endtask

    task automatic test_back_to_back();
        int first, last, vcyc, nrd;
        do_reset();
        fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33); fq.push_back(8'h44);
        hold_empty = 1'b0; out_ready = 1'b1;
        refresh();
        first = -1; last = -1; vcyc = -1; nrd = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (fifo_read_en) begin
                if (first < 0) first = c;
                last = c; nrd++;
            end
            if (out_valid) begin vcyc = c; break; end
            step();
        end
        total++;
        if (first < 0 || vcyc - first != RATIO + 1) begin
            bad++; $display("FAIL b2b_latency: first read %0d valid %0d need gap %0d", first, vcyc, RATIO + 1);
        end
        total++;
        if (nrd != 4 || last - first != 3) begin
            bad++; $display("FAIL b2b_reads: %0d reads over cycles %0d..%0d need 4 consecutive", nrd, first, last);
        end
        total++;
        if (out_data !== 32'h44332211) begin bad++; $display("FAIL b2b_data: got %h need 44332211", out_data); end
        total++;
        if (out_keep !== 4'hF) begin bad++; $display("FAIL b2b_keep: got %b need 1111", out_keep); end
        step();
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_handshake: out_valid=%b need 0", out_valid); end
        total++;
        if (acc_d.size() != 1 || acc_d[0] !== 32'h44332211 || acc_k[0] !== 4'hF) begin
            bad++; $display("FAIL b2b_accepted: count=%0d need 1 word 44332211", acc_d.size());
        end
    endtask

    task automatic test_backpressure();
        logic [OW-1:0] exp_w, saved;
        int seen;
        do_reset();
        exp_w = '0;
        for (int i = 0; i < 8; i++) begin
            fq.push_back(WIDTH'($urandom));
            if (i < RATIO) exp_w[i*WIDTH +: WIDTH] = fq[i];
        end
        hold_empty = 1'b0; out_ready = 1'b0;
        refresh();
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (out_valid) begin seen = 1; break; end
            step();
        end
        saved = out_data;
        total++;
        if (!seen || saved !== exp_w) begin
            bad++; $display("FAIL bp_word: valid=%0d data=%h need %h", seen, saved, exp_w);
        end
        for (int c = 0; c < 10; c++) begin
            step();
            #1;
            total++;
            if (out_data !== saved || out_valid !== 1'b1 || fifo_read_en !== 1'b0) begin
                bad++; $display("FAIL bp_hold cycle %0d: data=%h valid=%b rd=%b need %h 1 0",
                                c, out_data, out_valid, fifo_read_en, saved);
            end
        end
        out_ready = 1'b1;
        step();
        #1;
        total++;
        if (out_valid !== 1'b0 || acc_d.size() != 1 || acc_d[0] !== exp_w) begin
            bad++; $display("FAIL bp_accept: valid=%b words=%0d need 0 and 1 word %h", out_valid, acc_d.size(), exp_w);
        end
    endtask

    task automatic test_sparse();
        do_reset();
        for (int i = 1; i <= 8; i++) fq.push_back(WIDTH'(i));
        out_ready = 1'b1; hold_empty = 1'b0;
        for (int c = 0; c < 100 && acc_d.size() < 2; c++) begin
            hold_empty = !hold_empty;
            refresh();
            step();
        end
        total++;
        if (acc_d.size() != 2) begin bad++; $display("FAIL sparse_count: got %0d words need 2", acc_d.size()); end
        total++;
        if (acc_d[0] !== 32'h04030201) begin bad++; $display("FAIL sparse_word0: got %h need 04030201", acc_d[0]); end
        total++;
        if (acc_d[1] !== 32'h08070605) begin bad++; $display("FAIL sparse_word1: got %h need 08070605", acc_d[1]); end
    endtask

    task automatic test_reset_midword();
        do_reset();
        fq.push_back(8'h55); fq.push_back(8'h66); fq.push_back(8'h77);
        hold_empty = 1'b0; out_ready = 1'b1;
        refresh();
        for (int c = 0; c < 20 && got.size() < 2; c++) step();
        total++;
        if (got.size() != 2 || !infl_v) begin
            bad++; $display("FAIL midword_setup: lanes=%0d inflight=%b need 2 and 1", got.size(), infl_v);
        end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_keep !== '0 || out_data !== '0) begin
            bad++; $display("FAIL midword_cleared: valid=%b keep=%b data=%h need all zero", out_valid, out_keep, out_data);
        end
        fq.push_back(8'hA0); fq.push_back(8'hA1); fq.push_back(8'hA2); fq.push_back(8'hA3);
        refresh();
        for (int c = 0; c < 30 && acc_d.size() < 1; c++) step();
        total++;
        if (acc_d.size() != 1 || acc_d[0] !== 32'hA3A2A1A0) begin
            bad++; $display("FAIL midword_word: words=%0d data=%h need A3A2A1A0", acc_d.size(), acc_d[0]);
        end
    endtask

    task automatic test_timeout();
        int vc;
        do_reset();
        fq.push_back(8'h0A); fq.push_back(8'h0B); fq.push_back(8'h0C);
        hold_empty = 1'b0; out_ready = 1'b1;
        refresh();
        for (int c = 0; c < 20 && got.size() < 3; c++) step();
        vc = -1;
        for (int c = 1; c <= 40; c++) begin
            step();
            #1;
            if (out_valid) begin vc = c; break; end
        end
`ifdef PACKER_TIMEOUT_EN
        total++;
        if (vc != TIMEOUT) begin bad++; $display("FAIL timeout_delay: valid after %0d cycles need %0d", vc, TIMEOUT); end
        total++;
        if (out_data !== 32'h000C0B0A || out_keep !== 4'h7) begin
            bad++; $display("FAIL timeout_word: data=%h keep=%b need 000c0b0a 0111", out_data, out_keep);
        end
        step();
        total++;
        if (acc_k.size() != 1 || acc_k[0] !== 4'h7) begin
            bad++; $display("FAIL timeout_accept: words=%0d need 1 with keep 0111", acc_k.size());
        end
`else
        total++;
        if (vc != -1) begin bad++; $display("FAIL no_timeout: out_valid after %0d cycles need none", vc); end
`endif
    endtask

    task automatic test_wrap();
        logic [OW-1:0] exp_w;
        do_reset();
        for (int i = 0; i < 64; i++) fq.push_back(WIDTH'(i));
        hold_empty = 1'b0;
        refresh();
        for (int c = 0; c < 2000 && acc_d.size() < 16; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        total++;
        if (acc_d.size() != 16) begin bad++; $display("FAIL wrap_count: got %0d words need 16", acc_d.size()); end
        for (int w = 0; w < 16 && w < acc_d.size(); w++) begin
            for (int k = 0; k < RATIO; k++) exp_w[k*WIDTH +: WIDTH] = WIDTH'(RATIO * w + k);
            total++;
            if (acc_d[w] !== exp_w) begin bad++; $display("FAIL wrap_word%0d: got %h need %h", w, acc_d[w], exp_w); end
        end
        total++;
        if (fq.size() != 0 || got.size() != 0) begin
            bad++; $display("FAIL wrap_leftover: fifo=%0d lanes=%0d need 0 0", fq.size(), got.size());
        end
    endtask

    initial begin
        reset_n = 1'b0; fifo_empty = 1'b1; out_ready = 1'b0; fifo_read_data = '0;
        @(negedge rd_clk);
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_sparse();
        test_reset_midword();
        test_timeout();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "time limit");
    end
endmodule
